seq_scan_ctrl: RTL
==================

Name: seq_scan_ctrl

Overview:
Word-level controller for the serial "010"/"11" pattern detector path. Accepts a parallel word through a valid/ready handshake and serializes it MSB-first, one bit per cycle, onto a serial output that can feed a downstream bit-serial detector. Runs the same overlapping detection internally and returns the per-word match count through a second valid/ready handshake. Sits between a word-oriented producer and the serial detection datapath.

Parameters:
WIDTH, 8, bits per input word; legal values are 2 to 64.
CNT_W, 4, match-count width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  input word valid.
in_ready  out  1  controller can accept a word.
in_data  in  WIDTH  word to scan, MSB first.
flush  in  1  synchronous abort of the current scan.
ser_valid  out  1  ser_data is carrying a live bit.
ser_data  out  1  current serialized bit.
out_valid  out  1  result valid.
out_ready  in  1  consumer takes the result.
out_count  out  CNT_W  number of matches in the word.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, in_ready=1, ser_valid=0, ser_data=0, out_valid=0, out_count=0, bit index=0, detector history cleared.
- State machine IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, load in_data into the shift register, clear the count, clear history (unless SEQ_CARRY_EN), and go to SHIFT.
- SHIFT:
  - in_ready=0 and ser_valid=1.
  - ser_data is the current MSB of the shift register.
  - Each cycle: shift left, increment the bit index, update the count.
  - After WIDTH cycles, go to DONE.
- Latency: word accepted at edge E0 -> bits presented during cycles E0..E(WIDTH-1) -> out_valid rises at edge E(WIDTH).
- Detection, for bit sequence b0..b(WIDTH-1), MSB first:
  - A match is counted at position i if (b(i-1),b(i))==11, or (b(i-2),b(i-1),b(i))==010.
  - Overlapping matches are allowed.
  - At most one match per bit.
  - Positions with insufficient history do not match.
- DONE:
  - out_valid=1, out_count held stable, ser_valid=0, in_ready=0.
  - On out_ready, clear out_valid and go to IDLE.
  - The next word is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- flush:
  - In SHIFT or DONE, go to IDLE next edge, with out_valid=0 and ser_valid=0. The count is discarded.
  - In IDLE, flush has priority over acceptance: a word offered in that cycle is not accepted.
- Backpressure: out_ready held low keeps DONE indefinitely, with out_count unchanged.
- in_data changes while in SHIFT are ignored.
- The count saturates at 2^CNT_W-1. This cannot happen with legal parameters.

Optional Feature:
SEQ_CARRY_EN
- Defined:
  - The last two scanned bits are kept across words, so b0/b1 of a new word can complete a match with the previous word's tail.
  - History is cleared only by reset or flush.
- Undefined: history is cleared at every word acceptance and each word is scanned independently.

Test Plan:
1. Reset and idle, WIDTH=8: hold rst low, then release -> in_ready=1, out_valid=0, out_count=0, ser_valid=0.
2. Match counts:
   - 0x00 -> 0.
   - 0xFF -> 7.
   - 0x52 -> 3 (010 at positions 2, 4, 7).
   - 0xDA -> 3.
   - out_valid rises exactly 8 cycles after the accept edge.
   - ser_data during SHIFT equals the word MSB first.
3. Backpressure: 0x52 with out_ready low for 5 cycles -> out_valid and out_count=3 stay stable, in_ready=0; a single out_ready pulse returns to IDLE.
4. Flush: send 0xFF and assert flush after 3 SHIFT cycles -> IDLE next cycle, no out_valid, ser_valid=0; a following 0x00 reports 0.
5. Async reset mid-SHIFT: drop rst between clock edges -> outputs take their reset values immediately.
6. SEQ_CARRY_EN: 0x01 then 0x80:
   - Defined -> counts 0 then 1.
   - Undefined -> counts 0 then 0.
   - A flush between the two words yields 0, 0 in both builds.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// Word-in, bit-serial-out scan controller with internal overlapping "11"/"010" match counter.
// Optional macro SEQ_CARRY_EN: keep the last two scanned bits across words (cleared only by reset/flush).
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_count is stable while out_valid is high.

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_out_count;
  logic [1:0]       r_hist;     // [0] = previous bit, [1] = the one before
  logic [1:0]       r_hist_vld;
  logic             r_in_ready;
  logic             r_ser_valid;
  logic             r_ser_data;
  logic             r_out_valid;

  logic             w_bit;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_bit   = r_shift[WIDTH-1];
  // The two patterns need opposite current bits, so at most one can fire per bit.
  assign w_match = (r_hist_vld[0] & r_hist[0] & w_bit) |
                   (r_hist_vld[1] & r_hist_vld[0] & ~r_hist[1] & r_hist[0] & ~w_bit);
  assign w_cnt_next = (r_count == CNT_MAX) ? r_count
                                           : r_count + {{(CNT_W-1){1'b0}}, w_match};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_out_count <= '0;
      r_hist      <= '0;
      r_hist_vld  <= '0;
      r_in_ready  <= 1'b1;
      r_ser_valid <= 1'b0;
      r_ser_data  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_hist      <= '0;
      r_hist_vld  <= '0;
      r_in_ready  <= 1'b1;
      r_ser_valid <= 1'b0;
      r_ser_data  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_shift     <= in_data;
            r_idx       <= '0;
            r_count     <= '0;
`ifdef SEQ_CARRY_EN
            r_hist_vld  <= r_hist_vld;
`else
            r_hist_vld  <= '0;
`endif
            r_state     <= S_SHIFT;
            r_in_ready  <= 1'b0;
            r_ser_valid <= 1'b1;
            r_ser_data  <= in_data[WIDTH-1];
          end
        end
        S_SHIFT: begin
          r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
          r_idx      <= r_idx + IDX_W'(1);
          r_count    <= w_cnt_next;
          r_hist     <= {r_hist[0], w_bit};
          r_hist_vld <= {r_hist_vld[0], 1'b1};
          if (r_idx == LAST_IDX) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_count <= w_cnt_next;
            r_ser_valid <= 1'b0;
            r_ser_data  <= 1'b0;
          end else begin
            r_ser_data  <= r_shift[WIDTH-2];
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_ser_valid <= 1'b0;
          r_ser_data  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign ser_valid = r_ser_valid;
  assign ser_data  = r_ser_data;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign dbg_state = r_state;

endmodule
